// File: rtl/census_wta_pkg.sv
// ============================================================================
// census_pkg
// Shared types and constants for the census winner-take-all selector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package census_pkg;

  localparam int DEF_COST_W = 8;
  localparam int DEF_DISP_W = 8;

  typedef logic [DEF_COST_W-1:0] cost_t;

  localparam cost_t COST_MAX = '1;

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/census_wta_min2.sv
// ============================================================================
// census_min2
// Combinational best/second-best cost update for one disparity beat.
// Second-best tracking is compiled only with CENSUS_WTA_UNIQUE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module census_min2 #(
  parameter int COST_W = 8,
  parameter int DISP_W = 8
) (
  input  logic              i_first,
  input  logic [COST_W-1:0] i_cost,
  input  logic [DISP_W-1:0] i_idx,
  input  logic [COST_W-1:0] i_best,
  input  logic [DISP_W-1:0] i_best_idx,
`ifdef CENSUS_WTA_UNIQUE_EN
  input  logic [COST_W-1:0] i_second,
  output logic [COST_W-1:0] o_second,
`endif
  output logic [COST_W-1:0] o_best,
  output logic [DISP_W-1:0] o_best_idx
);

  // Strict less-than keeps the lower disparity on a tie.
  always_comb begin
    o_best     = i_best;
    o_best_idx = i_best_idx;
    if (i_first) begin
      o_best     = i_cost;
      o_best_idx = '0;
    end else if (i_cost < i_best) begin
      o_best     = i_cost;
      o_best_idx = i_idx;
    end
  end

`ifdef CENSUS_WTA_UNIQUE_EN
  always_comb begin
    o_second = i_second;
    if (i_first) begin
      o_second = '1;
    end else if (i_cost < i_best) begin
      if (i_best < i_second) o_second = i_best;
    end else if (i_cost < i_second) begin
      o_second = i_cost;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/census_wta.sv
// ============================================================================
// census_wta
// Winner-take-all disparity selector with valid/ready streams on both sides.
// Optional uniqueness test enabled by macro CENSUS_WTA_UNIQUE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module census_wta
  import census_pkg::*;
#(
  parameter int DISP_MAX    = 64,
  parameter int COST_W      = DEF_COST_W,
  parameter int DISP_W      = DEF_DISP_W,
  parameter int UNIQ_MARGIN = 4
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iClear,
  input  logic [COST_W-1:0] iCost,
  input  logic              iValid,
  input  logic              iLast,
  output logic              oReady,
  output logic [DISP_W-1:0] oDisp,
  output logic [COST_W-1:0] oCost,
  output logic              oUnique,
  output logic              oValid,
  input  logic              iReady,
  output logic [31:0]       oCnt,
  output logic              oOverrun
);

  if (DISP_MAX < 2 || DISP_MAX > 256 || DISP_MAX > (1 << DISP_W) ||
      UNIQ_MARGIN >= (1 << COST_W)) begin : g_param_err
    $error("census_wta: illegal parameter combination");
  end

  state_t              state_q, state_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [COST_W-1:0]   best_q, best_d;
  logic [DISP_W-1:0]   idx_q, idx_d;
  logic [DISP_W-1:0]   res_disp_q, res_disp_d;
  logic [COST_W-1:0]   res_cost_q, res_cost_d;
  logic                uniq_q, uniq_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                overrun_q, overrun_d;

  logic                valid;
  logic                accept;
  logic                first;
  logic                at_end;
  logic                pix_end;
  logic [COST_W-1:0]   nxt_best;
  logic [DISP_W-1:0]   nxt_idx;
  logic                uniq_calc;

  assign valid   = (state_q == ST_HOLD);
  assign oReady  = !valid || iReady;
  assign accept  = iValid && oReady;
  assign first   = (disp_q == '0);
  assign at_end  = (disp_q == DISP_W'(DISP_MAX - 1));
  assign pix_end = accept && (iLast || at_end);

`ifdef CENSUS_WTA_UNIQUE_EN
  logic [COST_W-1:0]   second_q, second_d;
  logic [COST_W-1:0]   nxt_second;

  census_min2 #(.COST_W(COST_W), .DISP_W(DISP_W)) u_min2 (
    .i_first    (first),
    .i_cost     (iCost),
    .i_idx      (disp_q),
    .i_best     (best_q),
    .i_best_idx (idx_q),
    .i_second   (second_q),
    .o_second   (nxt_second),
    .o_best     (nxt_best),
    .o_best_idx (nxt_idx)
  );

  // A lone disparity has no competitor, so it is unique by definition.
  assign uniq_calc = first || ((nxt_second - nxt_best) >= COST_W'(UNIQ_MARGIN));
`else
  census_min2 #(.COST_W(COST_W), .DISP_W(DISP_W)) u_min2 (
    .i_first    (first),
    .i_cost     (iCost),
    .i_idx      (disp_q),
    .i_best     (best_q),
    .i_best_idx (idx_q),
    .o_best     (nxt_best),
    .o_best_idx (nxt_idx)
  );

  assign uniq_calc = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    best_d     = best_q;
    idx_d      = idx_q;
    res_disp_d = res_disp_q;
    res_cost_d = res_cost_q;
    uniq_d     = uniq_q;
    cnt_d      = cnt_q;
    overrun_d  = overrun_q;
`ifdef CENSUS_WTA_UNIQUE_EN
    second_d   = second_q;
`else
    uniq_d     = 1'b1;
`endif
    if (iClear) begin
      state_d   = ST_SCAN;
      disp_d    = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (valid && iReady) begin
        cnt_d   = cnt_q + 32'd1;
        state_d = ST_SCAN;
      end
      if (accept) begin
        best_d = nxt_best;
        idx_d  = nxt_idx;
`ifdef CENSUS_WTA_UNIQUE_EN
        second_d = nxt_second;
`endif
        if (pix_end) begin
          res_disp_d = nxt_idx;
          res_cost_d = nxt_best;
          uniq_d     = uniq_calc;
          state_d    = ST_HOLD;
          disp_d     = '0;
          if (!iLast) overrun_d = 1'b1;
        end else begin
          disp_d = disp_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= ST_SCAN;
      disp_q     <= '0;
      best_q     <= '1;
      idx_q      <= '0;
      res_disp_q <= '0;
      res_cost_q <= '1;
      uniq_q     <= 1'b0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
`ifdef CENSUS_WTA_UNIQUE_EN
      second_q   <= '1;
`endif
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      best_q     <= best_d;
      idx_q      <= idx_d;
      res_disp_q <= res_disp_d;
      res_cost_q <= res_cost_d;
      uniq_q     <= uniq_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
`ifdef CENSUS_WTA_UNIQUE_EN
      second_q   <= second_d;
`endif
    end
  end

  assign oValid   = valid;
  assign oDisp    = res_disp_q;
  assign oCost    = res_cost_q;
  assign oUnique  = uniq_q;
  assign oCnt     = cnt_q;
  assign oOverrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_census_wta.sv
// ============================================================================
// tb_census_wta
// Scoreboard bench for census_wta (DISP_MAX=8, UNIQ_MARGIN=4).
// Uniqueness expectations follow CENSUS_WTA_UNIQUE_EN when defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_census_wta;

  logic        clk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iClear = 1'b0;
  logic [7:0]  iCost = '0;
  logic        iValid = 1'b0;
  logic        iLast = 1'b0;
  logic        iReady = 1'b1;
  logic        oReady, oUnique, oValid, oOverrun;
  logic [7:0]  oDisp, oCost;
  logic [31:0] oCnt;

  typedef struct {
    logic [7:0]  disp;
    logic [7:0]  cost;
    logic        uniq;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   pix_cnt = 0;

  census_wta #(.DISP_MAX(8), .COST_W(8), .DISP_W(8), .UNIQ_MARGIN(4)) dut (
    .iClk(clk), .iReset_n(iReset_n), .iClear(iClear), .iCost(iCost),
    .iValid(iValid), .iLast(iLast), .oReady(oReady), .oDisp(oDisp),
    .oCost(oCost), .oUnique(oUnique), .oValid(oValid), .iReady(iReady),
    .oCnt(oCnt), .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  function automatic logic eu(input logic m);
`ifdef CENSUS_WTA_UNIQUE_EN
    return m;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push_exp(input int d, input int c, input logic m);
    exp_t e;
    e.disp = d[7:0];
    e.cost = c[7:0];
    e.uniq = eu(m);
    e.cnt  = pix_cnt;
    sb.push_back(e);
    pix_cnt++;
  endtask

  task automatic send_beat(input int cost, input bit last);
    bit acc = 1'b0;
    int k = 0;
    iValid = 1'b1;
    iCost  = cost[7:0];
    iLast  = last;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = oReady;
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) fail_now("beat_accept");
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic pixel(input int n, input int c[10], input bit with_last,
                       input int d, input int cst, input logic m);
    push_exp(d, cst, m);
    for (int i = 0; i < n; i++) send_beat(c[i], with_last && (i == n - 1));
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (sb.size() != 0) fail_now("drain");
  endtask

  // Compares the head result every cycle it is presented; pops on handshake.
  always @(negedge clk) begin
    if (iReset_n && oValid) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        n_chk++;
        if (oDisp === sb[0].disp && oCost === sb[0].cost &&
            oUnique === sb[0].uniq && oCnt === sb[0].cnt) begin
          n_pass++;
        end else begin
          $display("FAIL result: got disp=%0d cost=%0d uniq=%0d cnt=%0d expected disp=%0d cost=%0d uniq=%0d cnt=%0d",
                   oDisp, oCost, oUnique, oCnt, sb[0].disp, sb[0].cost, sb[0].uniq, sb[0].cnt);
        end
        if (iReady) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovalid", oValid, 0);
    chk("rst_odisp", oDisp, 0);
    chk("rst_ocost", oCost, 8'hFF);
    chk("rst_ounique", oUnique, 0);
    chk("rst_ocnt", oCnt, 0);
    chk("rst_overrun", oOverrun, 0);
    iReset_n = 1'b1;
    @(posedge clk);
    #1;

    pixel(8, '{9, 7, 3, 5, 3, 8, 6, 4, 0, 0}, 1, 2, 3, 0);
    chk("latency_ovalid", oValid, 1);
    drain();
    chk("cnt_after_p1", oCnt, 1);

    // Back-to-back pixels with iReady held high.
    pixel(4, '{5, 5, 5, 5, 0, 0, 0, 0, 0, 0}, 1, 0, 5, 0);
    pixel(4, '{20, 10, 30, 15, 0, 0, 0, 0, 0, 0}, 1, 1, 10, 1);
    pixel(3, '{20, 10, 13, 0, 0, 0, 0, 0, 0, 0}, 1, 1, 10, 0);
    pixel(1, '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 42, 1);
    drain();

    // Consumer stall with the next pixel already waiting.
    iReady = 1'b0;
    pixel(2, '{7, 2, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 1, 2, 1);
    push_exp(2, 1, 0);
    iValid = 1'b1;
    iCost  = 8'd3;
    iLast  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_oready", oReady, 0);
      chk("stall_ovalid", oValid, 1);
    end
    @(posedge clk);
    #1;
    iReady = 1'b1;
    @(negedge clk);
    chk("release_oready", oReady, 1);
    @(posedge clk);
    #1;
    iValid = 1'b0;
    send_beat(9, 0);
    send_beat(1, 1);
    drain();
    chk("cnt_before_clear", oCnt, 7);

    // Clear mid-pixel; the beat presented with the clear is ignored.
    send_beat(2, 0);
    send_beat(2, 0);
    send_beat(2, 0);
    iClear = 1'b1;
    iValid = 1'b1;
    iCost  = 8'd0;
    iLast  = 1'b1;
    @(posedge clk);
    #1;
    iClear = 1'b0;
    iValid = 1'b0;
    iLast  = 1'b0;
    chk("clear_ocnt", oCnt, 0);
    chk("clear_ovalid", oValid, 0);
    pix_cnt = 0;
    pixel(2, '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 1, 0, 0);
    drain();
    chk("cnt_after_clear", oCnt, 1);

    // Overrun: 8 beats without iLast close the pixel, then a new one starts.
    chk("overrun_before", oOverrun, 0);
    pixel(8, '{50, 40, 60, 30, 70, 45, 35, 80, 0, 0}, 0, 3, 30, 1);
    chk("overrun_set", oOverrun, 1);
    pixel(2, '{11, 6, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 1, 6, 1);
    drain();
    chk("cnt_after_overrun", oCnt, 3);

    // Asynchronous reset in the middle of a pixel.
    send_beat(4, 0);
    send_beat(9, 0);
    @(negedge clk);
    #2;
    iReset_n = 1'b0;
    #1;
    chk("arst_ovalid", oValid, 0);
    chk("arst_odisp", oDisp, 0);
    chk("arst_ocost", oCost, 8'hFF);
    chk("arst_ounique", oUnique, 0);
    chk("arst_ocnt", oCnt, 0);
    chk("arst_overrun", oOverrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    iReset_n = 1'b1;
    pix_cnt = 0;
    pixel(2, '{4, 3, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 1, 3, 0);
    drain();
    chk("cnt_after_reset", oCnt, 1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
